// File: rtl/toggle_event_receiver.sv
// Converts transitions of a toggle-encoded request level into discrete events,
// queued in a saturating pending counter and drained over a valid/ready handshake.
module toggle_event_receiver #(
    parameter int SYNC_STAGES   = 0,
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     toggle_state,
    output logic                     event_valid,
    input  logic                     event_ready,
    output logic [COUNTER_WIDTH-1:0] pending_count,
    output logic                     overflow,
    input  logic                     clear_overflow
);

    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = COUNTER_WIDTH'(1);

    logic                     synced_s;
    logic                     sampled_r;
    logic                     edge_s;
    logic                     pop_s;
    logic                     sat_s;
    logic [COUNTER_WIDTH-1:0] count_r;
    logic [COUNTER_WIDTH-1:0] count_next_s;
    logic                     valid_r;
    logic                     overflow_r;
    logic                     overflow_next_s;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign synced_s = toggle_state;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_r;

            // Resync chain; reset preloads the raw level so release creates no event.
            always_ff @(posedge clock) begin
                if (reset) begin
                    sync_r <= {SYNC_STAGES{toggle_state}};
                end else begin
                    sync_r[0] <= toggle_state;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_r[i] <= sync_r[i-1];
                    end
                end
            end

            assign synced_s = sync_r[SYNC_STAGES-1];
        end
    endgenerate

    assign edge_s = synced_s ^ sampled_r;
    assign pop_s  = valid_r & event_ready;

    // Counter/overflow next state; a detect and a pop in the same cycle cancel out.
    always_comb begin
        count_next_s    = count_r;
        sat_s           = 1'b0;
        overflow_next_s = overflow_r;
        case ({edge_s, pop_s})
            2'b10: begin
                if (count_r == COUNT_MAX) begin
                    sat_s = 1'b1;
                end else begin
                    count_next_s = count_r + COUNT_ONE;
                end
            end
            2'b01:   count_next_s = count_r - COUNT_ONE;
            default: count_next_s = count_r;
        endcase
        if (sat_s) begin
            overflow_next_s = 1'b1;
        end else if (clear_overflow) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // Reference flop, pending counter and registered status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            sampled_r  <= toggle_state;
            count_r    <= {COUNTER_WIDTH{1'b0}};
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            sampled_r  <= synced_s;
            count_r    <= count_next_s;
            valid_r    <= (count_next_s != {COUNTER_WIDTH{1'b0}});
            overflow_r <= overflow_next_s;
        end
    end

    assign event_valid   = valid_r;
    assign pending_count = count_r;
    assign overflow      = overflow_r;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Self-checking bench: directed and random stimulus on a same-clock instance
// checked against an event-count model, plus directed latency/reset checks on a 2-stage instance.
module tb_toggle_event_receiver;

    logic       clock;
    logic       reset, toggle_state, event_ready, clear_overflow;
    logic       event_valid, overflow;
    logic [3:0] pending_count;

    logic       reset2, toggle2, ready2, clear2;
    logic       valid2, overflow2;
    logic [3:0] count2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pending events, overflow flag, last level seen.
    int   m_cnt;
    logic m_ovf;
    logic m_prev;

    toggle_event_receiver #(.SYNC_STAGES(0), .COUNTER_WIDTH(4)) dut0 (
        .clock(clock), .reset(reset), .toggle_state(toggle_state),
        .event_valid(event_valid), .event_ready(event_ready),
        .pending_count(pending_count), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    toggle_event_receiver #(.SYNC_STAGES(2), .COUNTER_WIDTH(4)) dut2 (
        .clock(clock), .reset(reset2), .toggle_state(toggle2),
        .event_valid(valid2), .event_ready(ready2),
        .pending_count(count2), .overflow(overflow2),
        .clear_overflow(clear2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs present at the edge, then compare.
    task automatic tick();
        logic det, pop, lost;
        if (reset) begin
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_prev = toggle_state;
        end else begin
            det  = (toggle_state != m_prev);
            pop  = (m_cnt > 0) && event_ready;
            lost = 1'b0;
            if (det && !pop) begin
                if (m_cnt == 15) lost = 1'b1;
                else m_cnt = m_cnt + 1;
            end else if (pop && !det) begin
                m_cnt = m_cnt - 1;
            end
            if (lost) m_ovf = 1'b1;
            else if (clear_overflow) m_ovf = 1'b0;
            m_prev = toggle_state;
        end
        @(posedge clock);
        #1;
        chk("model_count", 32'(pending_count), 32'(m_cnt));
        chk("model_valid", 32'(event_valid), 32'(m_cnt != 0));
        chk("model_ovf", 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        reset = 1'b1; toggle_state = 1'b1; event_ready = 1'b0; clear_overflow = 1'b0;
        reset2 = 1'b1; toggle2 = 1'b0; ready2 = 1'b0; clear2 = 1'b0;
        m_cnt = 0; m_ovf = 1'b0; m_prev = 1'b0;

        // Reset with toggle high, then hold: no spurious event.
        tick();
        chk("reset_count", 32'(pending_count), 32'd0);
        chk("reset_valid", 32'(event_valid), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);
        reset = 1'b0; reset2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 32'(event_valid), 32'd0);
            chk("hold_count", 32'(pending_count), 32'd0);
        end

        // Three toggles with no consumer, then drain.
        for (int i = 1; i <= 3; i++) begin
            toggle_state = ~toggle_state;
            tick();
            chk("fill_count", 32'(pending_count), 32'(i));
        end
        event_ready = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            tick();
            chk("drain_count", 32'(pending_count), 32'(i));
        end
        chk("drain_valid", 32'(event_valid), 32'd0);
        tick();
        chk("no_underflow", 32'(pending_count), 32'd0);

        // Saturation: 17 toggles into a 15-deep counter.
        event_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            toggle_state = ~toggle_state;
            tick();
        end
        chk("sat_count", 32'(pending_count), 32'd15);
        chk("sat_ovf", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_count", 32'(pending_count), 32'd15);

        // Detect and pop together at max: no change, no overflow.
        toggle_state = ~toggle_state;
        event_ready = 1'b1;
        tick();
        chk("both_count", 32'(pending_count), 32'd15);
        chk("both_ovf", 32'(overflow), 32'd0);
        event_ready = 1'b0;

        // Two-stage sync instance: latency of a single toggle.
        toggle2 = 1'b1;
        tick(); chk("s2_e1_valid", 32'(valid2), 32'd0);
        tick(); chk("s2_e2_valid", 32'(valid2), 32'd0);
        tick(); chk("s2_e3_valid", 32'(valid2), 32'd1);
        chk("s2_e3_count", 32'(count2), 32'd1);
        for (int i = 0; i < 4; i++) begin
            toggle2 = ~toggle2;
            tick();
        end
        tick(); tick();
        chk("s2_count5", 32'(count2), 32'd5);
        // Reset mid-stream with one toggle still in the sync chain.
        toggle2 = ~toggle2;
        reset2 = 1'b1;
        tick();
        chk("s2_rst_count", 32'(count2), 32'd0);
        chk("s2_rst_valid", 32'(valid2), 32'd0);
        reset2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("s2_post_count", 32'(count2), 32'd0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 1000; i++) begin
            toggle_state   = 1'($urandom_range(0, 1));
            event_ready    = 1'($urandom_range(0, 1));
            clear_overflow = ($urandom_range(0, 7) == 0);
            reset          = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
